line_encoder_32x5_seq: RTL



---
 rtl/line_encoder_32x5_seq_pkg.sv | 26 ++
 rtl/line_encoder_32x5_seq_prio_enc.sv | 34 +++
 rtl/line_encoder_32x5_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/line_encoder_32x5_seq_pkg.sv
// Shared definitions for the sequential 32-line to 5-bit index encoder.
//   LINE_W / IDX_W : line-vector width and index width
//   CNT_W          : width of a count of set lines (0..32 needs 6 bits)
//   state_t        : scan FSM state encoding
//   popcount32()   : number of set bits in a line vector
package line_encoder_32x5_seq_pkg;

    localparam int LINE_W = 32;
    localparam int IDX_W  = 5;
    localparam int CNT_W  = 6;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    function automatic logic [CNT_W-1:0] popcount32(input logic [LINE_W-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < LINE_W; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/line_encoder_32x5_seq_prio_enc.sv
// Combinational 32-to-5 priority encoder.
//   vec_i       : line vector
//   msb_first_i : 0 = report lowest set bit, 1 = report highest set bit
//   idx_o       : index of the winning bit (0 when nothing is set)
//   any_o       : at least one bit of vec_i is set
module prio_enc_32x5
    import line_encoder_32x5_seq_pkg::*;
(
    input  logic [LINE_W-1:0] vec_i,
    input  logic              msb_first_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              any_o
);

    logic [IDX_W-1:0] idx_lo;
    logic [IDX_W-1:0] idx_hi;

    // Both scans let the last match win: descending scan ends on the lowest
    // set bit, ascending scan ends on the highest.
    always_comb begin
        idx_lo = '0;
        idx_hi = '0;
        for (int i = LINE_W - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_lo = IDX_W'(i);
        end
        for (int j = 0; j < LINE_W; j++) begin
            if (vec_i[j]) idx_hi = IDX_W'(j);
        end
    end

    assign idx_o = msb_first_i ? idx_hi : idx_lo;
    assign any_o = |vec_i;

endmodule

// File: rtl/line_encoder_32x5_seq.sv
// Sequential 32-line to 5-bit index encoder (inverse of the 5x32 decoder).
// Captures a multi-hot MASK and hands out the index of each set line, one per
// IDX_VALID/IDX_READY handshake, in priority order.
//
// Handshake: an index transfers on a rising CLK edge where IDX_VALID and
// IDX_READY are both 1; while IDX_READY is 0, IDX and IDX_VALID hold.
//
// Ports:
//   CLK, RESET        : clock, synchronous active-high reset
//   LOAD, MASK        : capture request and line vector (sampled only when BUSY=0)
//   BUSY              : captured lines remain to be emitted
//   IDX_VALID, IDX    : current highest-priority pending index
//   IDX_READY         : consumer accepts IDX
//   DONE              : one-cycle pulse after the last accept or a zero-mask load
//   REMAIN            : indices still to be emitted (only with LINE_ENC_POPCNT_EN)
//
// Build option: define LINE_ENC_POPCNT_EN to add the REMAIN output.
module line_encoder_32x5_seq
    import line_encoder_32x5_seq_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              LOAD,
    input  logic [LINE_W-1:0] MASK,
    output logic              BUSY,
    output logic              IDX_VALID,
    output logic [IDX_W-1:0]  IDX,
    input  logic              IDX_READY,
`ifdef LINE_ENC_POPCNT_EN
    output logic [CNT_W-1:0]  REMAIN,
`endif
    output logic              DONE
);

    state_t            state_q, state_d;
    logic [LINE_W-1:0] pending_q, pending_d;
    logic              done_q, done_d;
    logic [IDX_W-1:0]  enc_idx;
    logic              enc_any;
    logic [LINE_W-1:0] pending_clr;
    logic              hshake;

    prio_enc_32x5 u_prio_enc (
        .vec_i       (pending_q),
        .msb_first_i (MSB_FIRST),
        .idx_o       (enc_idx),
        .any_o       (enc_any)
    );

    assign BUSY      = (state_q == SCAN);
    assign IDX_VALID = BUSY & enc_any;
    // PENDING is zero outside SCAN, so the encoder already reports 0 there.
    assign IDX       = enc_idx;
    assign DONE      = done_q;
    assign hshake    = IDX_VALID & IDX_READY;
    assign pending_clr = pending_q & ~(LINE_W'(1) << enc_idx);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (LOAD) begin
                    if (MASK != '0) begin
                        pending_d = MASK;
                        state_d   = SCAN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                // LOAD is deliberately not looked at here.
                if (hshake) begin
                    pending_d = pending_clr;
                    if (pending_clr == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

`ifdef LINE_ENC_POPCNT_EN
    logic [CNT_W-1:0] remain_q, remain_d;

    always_comb begin
        remain_d = remain_q;
        if (state_q == IDLE) begin
            if (LOAD) remain_d = popcount32(MASK);
        end else if (hshake) begin
            remain_d = remain_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) remain_q <= '0;
        else       remain_q <= remain_d;
    end

    assign REMAIN = remain_q;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            pending_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            done_q    <= done_d;
        end
    end

endmodule
